ball_engine: RTL and testbench

- Ball-physics counterpart to the paddle controllers: consumes both paddle positions and produces the ball position they track.
- Integrates ball motion once per frame tick and handles wall bounces, paddle hits and misses.
- Keeps per-player scores and runs the serve / score-hold / game-over flow.
- Sits between the frame-tick generator, the two paddle blocks and the renderer. All coordinates are packed {x[31:16], y[15:0]}, unsigned, with the origin at the top-left.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/ball_step.sv | 110 +++++++++++
 rtl/ball_engine.sv | 157 +++++++++++++++
 tb/tb_ball_engine.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types, paddle geometry and packed-coordinate helpers for the pong ball logic.
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    SCORED    = 2'd2,
    GAME_OVER = 2'd3
  } ball_state_t;

  localparam logic [15:0] PADDLE_HEIGHT = 16'd100;
  localparam logic [15:0] PADDLE_WIDTH  = 16'd10;

  function automatic logic [15:0] pos_x(input logic [31:0] p);
    return p[31:16];
  endfunction

  function automatic logic [15:0] pos_y(input logic [31:0] p);
    return p[15:0];
  endfunction

  function automatic logic [31:0] pack_pos(input logic [15:0] x, input logic [15:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/ball_step.sv
// Combinational one-tick ball integrator: paddle hits, wall bounces and miss detection.
module ball_step
  import pong_pkg::*;
#(
  parameter logic [15:0] STEP_Y    = 16'd1,
  parameter logic [15:0] BALL_SIZE = 16'd8
) (
  input  logic [31:0] position,
  input  logic [31:0] dimensions,
  input  logic [31:0] left_paddle,
  input  logic [31:0] right_paddle,
  input  logic        dir_x,
  input  logic        dir_y,
  input  logic [15:0] step_x,
  output logic [31:0] next_position,
  output logic        next_dir_x,
  output logic        next_dir_y,
  output logic        hit,
  output logic        score_left,
  output logic        score_right
);

  logic [16:0] bx, by, wid, hgt, lpx, rpx, face, sx, sy, bs;
  logic        ovl_l, ovl_r;
  logic [15:0] nx, ny;
  logic        ndy;

  // Vertical overlap of the ball with a paddle whose top edge is py.
  function automatic logic overlaps(input logic [16:0] ball_y, input logic [16:0] py,
                                    input logic [16:0] ball_sz);
    return ((ball_y + ball_sz) > py) && (ball_y < (py + {1'b0, PADDLE_HEIGHT}));
  endfunction

  // All comparisons are widened to 17 bits so the sums cannot wrap.
  assign bx    = {1'b0, pos_x(position)};
  assign by    = {1'b0, pos_y(position)};
  assign wid   = {1'b0, pos_x(dimensions)};
  assign hgt   = {1'b0, pos_y(dimensions)};
  assign lpx   = {1'b0, pos_x(left_paddle)};
  assign rpx   = {1'b0, pos_x(right_paddle)};
  assign face  = lpx + {1'b0, PADDLE_WIDTH};
  assign sx    = {1'b0, step_x};
  assign sy    = {1'b0, STEP_Y};
  assign bs    = {1'b0, BALL_SIZE};
  assign ovl_l = overlaps(by, {1'b0, pos_y(left_paddle)}, bs);
  assign ovl_r = overlaps(by, {1'b0, pos_y(right_paddle)}, bs);

  // Horizontal axis: paddle hit takes priority over a miss.
  always_comb begin
    nx          = pos_x(position);
    next_dir_x  = dir_x;
    hit         = 1'b0;
    score_left  = 1'b0;
    score_right = 1'b0;
    if (dir_x) begin
      if (((bx + bs + sx) >= rpx) && ovl_r) begin
        nx         = pos_x(right_paddle) - BALL_SIZE;
        next_dir_x = 1'b0;
        hit        = 1'b1;
      end else if ((bx + bs + sx) >= wid) begin
        score_left = 1'b1;
      end else begin
        nx = pos_x(position) + step_x;
      end
    end else begin
      if ((bx <= (face + sx)) && ovl_l) begin
        nx         = face[15:0];
        next_dir_x = 1'b1;
        hit        = 1'b1;
      end else if (bx < sx) begin
        score_right = 1'b1;
      end else begin
        nx = pos_x(position) - step_x;
      end
    end
  end

  // Vertical axis, independent of the horizontal outcome.
  always_comb begin
    ny  = pos_y(position);
    ndy = dir_y;
    if (!dir_y) begin
      if (by < sy) begin
        ny  = 16'd0;
        ndy = 1'b1;
      end else begin
        ny = pos_y(position) - STEP_Y;
      end
    end else begin
      if ((by + bs + sy) >= hgt) begin
        ny  = pos_y(dimensions) - BALL_SIZE;
        ndy = 1'b0;
      end else begin
        ny = pos_y(position) + STEP_Y;
      end
    end
  end

  // A miss freezes the ball where it was before the tick.
  always_comb begin
    if (score_left || score_right) begin
      next_position = position;
      next_dir_y    = dir_y;
    end else begin
      next_position = pack_pos(nx, ny);
      next_dir_y    = ndy;
    end
  end

endmodule

// File: rtl/ball_engine.sv
// Ball FSM, scoring and serve flow around ball_step.
// Optional BALL_SPEEDUP_EN: horizontal step grows on each paddle hit up to 2*STEP_X.
module ball_engine
  import pong_pkg::*;
#(
  parameter logic [15:0] STEP_X     = 16'd2,
  parameter logic [15:0] STEP_Y     = 16'd1,
  parameter logic [15:0] BALL_SIZE  = 16'd8,
  parameter logic [7:0]  SCORE_HOLD = 8'd60,
  parameter logic [3:0]  WIN_SCORE  = 4'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dimensions,
  input  logic        frameTick,
  input  logic        serve,
  input  logic [31:0] leftPaddlePosition,
  input  logic [31:0] rightPaddlePosition,
  output logic [31:0] ballPosition,
  output logic [3:0]  scoreLeft,
  output logic [3:0]  scoreRight,
  output logic        hitPulse,
  output logic        scorePulse,
  output logic        gameOver
);

  ball_state_t state;
  logic        dir_x, dir_y;
  logic [7:0]  hold_cnt;
  logic [15:0] step_x;
  logic [31:0] next_pos;
  logic        next_dir_x, next_dir_y, hit, pt_left, pt_right;
  logic [3:0]  left_inc, right_inc;

`ifdef BALL_SPEEDUP_EN
  localparam logic [15:0] MAX_STEP_X = STEP_X << 1;
  logic [15:0] cur_step_x;
  assign step_x = cur_step_x;
`else
  assign step_x = STEP_X;
`endif

  assign left_inc  = scoreLeft + 4'd1;
  assign right_inc = scoreRight + 4'd1;

  ball_step #(
    .STEP_Y    (STEP_Y),
    .BALL_SIZE (BALL_SIZE)
  ) u_step (
    .position      (ballPosition),
    .dimensions    (dimensions),
    .left_paddle   (leftPaddlePosition),
    .right_paddle  (rightPaddlePosition),
    .dir_x         (dir_x),
    .dir_y         (dir_y),
    .step_x        (step_x),
    .next_position (next_pos),
    .next_dir_x    (next_dir_x),
    .next_dir_y    (next_dir_y),
    .hit           (hit),
    .score_left    (pt_left),
    .score_right   (pt_right)
  );

  // Game flow FSM with all outputs registered; dir_x=1 means rightwards, dir_y=1 downwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ballPosition <= 32'd0;
      scoreLeft    <= 4'd0;
      scoreRight   <= 4'd0;
      hitPulse     <= 1'b0;
      scorePulse   <= 1'b0;
      gameOver     <= 1'b0;
      dir_x        <= 1'b1;
      dir_y        <= 1'b1;
      hold_cnt     <= 8'd0;
`ifdef BALL_SPEEDUP_EN
      cur_step_x   <= STEP_X;
`endif
    end else begin
      hitPulse   <= 1'b0;
      scorePulse <= 1'b0;
      case (state)
        IDLE: begin
          ballPosition <= pack_pos(pos_x(dimensions) >> 1, pos_y(dimensions) >> 1);
          if (serve) begin
            state <= MOVE;
`ifdef BALL_SPEEDUP_EN
            cur_step_x <= STEP_X;
`endif
          end
        end
        MOVE: begin
          if (frameTick) begin
            if (pt_left) begin
              scoreLeft  <= left_inc;
              scorePulse <= 1'b1;
              dir_x      <= 1'b1;
              hold_cnt   <= 8'd0;
              if (left_inc == WIN_SCORE) begin
                state    <= GAME_OVER;
                gameOver <= 1'b1;
              end else begin
                state <= SCORED;
              end
            end else if (pt_right) begin
              scoreRight <= right_inc;
              scorePulse <= 1'b1;
              dir_x      <= 1'b0;
              hold_cnt   <= 8'd0;
              if (right_inc == WIN_SCORE) begin
                state    <= GAME_OVER;
                gameOver <= 1'b1;
              end else begin
                state <= SCORED;
              end
            end else begin
              ballPosition <= next_pos;
              dir_x        <= next_dir_x;
              dir_y        <= next_dir_y;
              hitPulse     <= hit;
`ifdef BALL_SPEEDUP_EN
              if (hit && (cur_step_x < MAX_STEP_X)) begin
                cur_step_x <= cur_step_x + 16'd1;
              end
`endif
            end
          end
        end
        SCORED: begin
          if (frameTick) begin
            if (hold_cnt == (SCORE_HOLD - 8'd1)) begin
              hold_cnt <= 8'd0;
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        GAME_OVER: begin
          if (serve) begin
            scoreLeft  <= 4'd0;
            scoreRight <= 4'd0;
            dir_x      <= 1'b1;
            gameOver   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: vector table for motion/bounce/hit plus hand sequences for scoring flow.
module tb_ball_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dimensions = 32'h0280_01E0;
  logic        frameTick = 1'b0;
  logic        serve = 1'b0;
  logic [31:0] leftPaddlePosition = 32'h0000_0258;
  logic [31:0] rightPaddlePosition = 32'h03E8_0258;
  logic [31:0] ballPosition;
  logic [3:0]  scoreLeft, scoreRight;
  logic        hitPulse, scorePulse, gameOver;

  localparam logic [31:0] DIM_STD = 32'h0280_01E0;
  localparam logic [31:0] DIM_FAR = 32'h04EC_0320;
  localparam logic [31:0] LP_OFF  = 32'h0000_0258;
  localparam logic [31:0] RP_OFF  = 32'h03E8_0258;
  localparam logic [31:0] CENTER  = 32'h0140_00F0;
  localparam logic [31:0] FROZEN  = 32'h0276_0190;

  int n_checks = 0;
  int n_pass   = 0;

  ball_engine dut (
    .clk                 (clk),
    .rst                 (rst),
    .dimensions          (dimensions),
    .frameTick           (frameTick),
    .serve               (serve),
    .leftPaddlePosition  (leftPaddlePosition),
    .rightPaddlePosition (rightPaddlePosition),
    .ballPosition        (ballPosition),
    .scoreLeft           (scoreLeft),
    .scoreRight          (scoreRight),
    .hitPulse            (hitPulse),
    .scorePulse          (scorePulse),
    .gameOver            (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        restart;
    logic [31:0] cdims;
    logic [31:0] pdims;
    logic [31:0] lpad;
    logic [31:0] rpad;
    int          ticks;
    logic [31:0] exp_pos;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk) frameTick = 1'b1;
    @(negedge clk) frameTick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Serve from IDLE with the centre taken from cd, then switch to the playing field pd.
  task automatic place_serve(input logic [31:0] cd, input logic [31:0] pd);
    dimensions = cd;
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    dimensions = pd;
  endtask

  task automatic tick_until_score(input int budget, output int used);
    used = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      used++;
      if (scorePulse) break;
    end
    if (!scorePulse) used = -1;
  endtask

  initial begin
    int used;

    // row 0 continues the serve sequence; rows 1-5 top wall; rows 6-10 paddle hits
    vecs[0]  = '{1'b0, DIM_STD, DIM_STD, LP_OFF, 32'h0258_0000, 10, 32'h0156_00FB, 1'b0};
    vecs[1]  = '{1'b1, 32'h0320_0014, 32'h0320_0014, LP_OFF, RP_OFF, 2, 32'h0194_000C, 1'b0};
    vecs[2]  = '{1'b0, 32'h0320_0014, 32'h0320_0014, LP_OFF, RP_OFF, 11, 32'h01AA_0001, 1'b0};
    vecs[3]  = '{1'b0, 32'h0320_0014, 32'h0320_0014, LP_OFF, RP_OFF, 1, 32'h01AC_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0320_0014, 32'h0320_0014, LP_OFF, RP_OFF, 1, 32'h01AE_0000, 1'b0};
    vecs[5]  = '{1'b0, 32'h0320_0014, 32'h0320_0014, LP_OFF, RP_OFF, 1, 32'h01B0_0001, 1'b0};
    vecs[6]  = '{1'b1, 32'h049C_01E0, 32'h049C_01E0, LP_OFF, 32'h0258_00C8, 1, 32'h0250_00F1, 1'b1};
    vecs[7]  = '{1'b0, 32'h049C_01E0, 32'h049C_01E0, LP_OFF, 32'h0258_00C8, 1, 32'h024E_00F2, 1'b0};
    vecs[8]  = '{1'b0, 32'h049C_01E0, 32'h049C_01E0, LP_OFF, 32'h0258_00C8, 5, 32'h0244_00F7, 1'b0};
    vecs[9]  = '{1'b0, 32'h049C_01E0, 32'h049C_01E0, 32'h0230_00C8, 32'h0258_00C8, 5, 32'h023A_00FC, 1'b1};
    vecs[10] = '{1'b0, 32'h049C_01E0, 32'h049C_01E0, 32'h0230_00C8, 32'h0258_00C8, 1, 32'h023C_00FD, 1'b0};

    // Reset state, then centring in IDLE
    @(negedge clk);
    chk("reset_pos", ballPosition, 32'd0);
    chk("reset_scores", {24'd0, scoreLeft, scoreRight}, 32'd0);
    chk("reset_flags", {29'd0, hitPulse, scorePulse, gameOver}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_center", ballPosition, CENTER);
    chk("idle_gameover", {31'd0, gameOver}, 32'd0);

    // serve and tick together only enter MOVE
    rightPaddlePosition = 32'h0258_0000;
    @(negedge clk) begin serve = 1'b1; frameTick = 1'b1; end
    @(negedge clk) begin serve = 1'b0; frameTick = 1'b0; end
    @(negedge clk);
    chk("serve_tick_hold", ballPosition, CENTER);
    tick();
    chk("first_move", ballPosition, 32'h0142_00F1);

    for (int v = 0; v < 11; v++) begin
      leftPaddlePosition  = vecs[v].lpad;
      rightPaddlePosition = vecs[v].rpad;
      if (vecs[v].restart) begin
        do_reset();
        place_serve(vecs[v].cdims, vecs[v].pdims);
      end else begin
        dimensions = vecs[v].pdims;
      end
      ticks(vecs[v].ticks);
      chk($sformatf("vec%0d_pos", v), ballPosition, vecs[v].exp_pos);
      chk($sformatf("vec%0d_hit", v), {31'd0, hitPulse}, {31'd0, vecs[v].exp_hit});
    end

    // Bounce off right paddle, then travel left into the wall: right scores
    leftPaddlePosition = LP_OFF;
    tick_until_score(400, used);
    chk("right_score_ticks", used, 32'd307);
    chk("right_score_val", {24'd0, scoreLeft, scoreRight}, 32'h0000_0001);
    chk("right_score_x", {16'd0, ballPosition[31:16]}, 32'd0);

    // Left point from (630,400), hold, re-serve
    do_reset();
    leftPaddlePosition  = LP_OFF;
    rightPaddlePosition = 32'h0258_0000;
    place_serve(DIM_FAR, DIM_STD);
    tick();
    chk("left_score", {28'd0, scoreLeft}, 32'd1);
    chk("score_pulse_hi", {31'd0, scorePulse}, 32'd1);
    chk("score_frozen", ballPosition, FROZEN);
    @(negedge clk);
    chk("score_pulse_lo", {31'd0, scorePulse}, 32'd0);
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    ticks(59);
    chk("hold_59", ballPosition, FROZEN);
    tick();
    @(negedge clk);
    chk("hold_60_idle", ballPosition, CENTER);
    place_serve(DIM_STD, DIM_STD);
    tick();
    chk("reserve_right", ballPosition, 32'h0142_00F1);

    rightPaddlePosition = RP_OFF;
    tick_until_score(400, used);
    chk("natural_score_ticks", used, 32'd155);
    chk("natural_score_val", {28'd0, scoreLeft}, 32'd2);

    // Run left up to WIN_SCORE
    for (int s = 3; s <= 11; s++) begin
      ticks(60);
      @(negedge clk);
      place_serve(DIM_FAR, DIM_STD);
      tick();
      chk($sformatf("score_%0d", s), {28'd0, scoreLeft}, s);
      chk($sformatf("gameover_%0d", s), {31'd0, gameOver}, (s == 11) ? 32'd1 : 32'd0);
    end
    ticks(3);
    chk("gameover_frozen", ballPosition, FROZEN);
    chk("gameover_held", {31'd0, gameOver}, 32'd1);
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    chk("restart_scores", {24'd0, scoreLeft, scoreRight}, 32'd0);
    chk("restart_gameover", {31'd0, gameOver}, 32'd0);
    @(negedge clk);
    chk("restart_center", ballPosition, CENTER);

    // One point, re-serve, then async reset mid-MOVE
    place_serve(DIM_FAR, DIM_STD);
    tick();
    ticks(60);
    @(negedge clk);
    place_serve(DIM_STD, DIM_STD);
    tick();
    chk("pre_rst_pos", ballPosition, 32'h0142_00F1);
    chk("pre_rst_score", {28'd0, scoreLeft}, 32'd1);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("async_rst_pos", ballPosition, 32'd0);
    chk("async_rst_all", {24'd0, scoreLeft, scoreRight} | {29'd0, hitPulse, scorePulse, gameOver}, 32'd0);
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
